// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-stage branch predictor: BHT counter states
// and branch comparator condition codes.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef enum logic [1:0] {
    CMP_NEZ   = 2'd0,
    CMP_GTZ   = 2'd1,
    CMP_LTZ   = 2'd2,
    CMP_NEVER = 2'd3
  } cmp_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter used by the BHT.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: 2-bit counter BHT lookup, update on
// resolution, registered redirect on mispredict, and branch statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [1:0]  res_control,
  input  logic        res_taken,
  input  logic        res_pred,
  input  logic [31:0] res_target,
  input  logic [31:0] res_fallthrough,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          bht_d [ENTRIES];
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [1:0]          ctr_next;
  logic                mispredict;
  logic                redirect_valid_q, redirect_valid_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;
  logic [31:0]         branch_count_q, branch_count_d;
  logic [31:0]         mispredict_count_q, mispredict_count_d;
  logic                unused_pc_bits;

  assign lookup_idx = lookup_pc[IDX_BITS+1:2];
  assign res_idx    = res_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                            res_pc[31:IDX_BITS+2], res_pc[1:0]};

  // No bypass: lookup always sees the pre-update counter.
  assign pred_taken = lookup_valid & bht_q[lookup_idx][1];

  sat_counter2 u_sat_counter2 (
    .ctr   (bht_q[res_idx]),
    .taken (res_taken),
    .next  (ctr_next)
  );

  assign mispredict = res_valid & (res_taken != res_pred);

  always_comb begin
    bht_d              = bht_q;
    redirect_valid_d   = mispredict;
    redirect_pc_d      = 32'd0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res_valid && (res_control != CMP_NEVER)) bht_d[res_idx] = ctr_next;
    if (mispredict) redirect_pc_d = res_taken ? res_target : res_fallthrough;
    if (res_valid && (branch_count_q != 32'hFFFF_FFFF))
      branch_count_d = branch_count_q + 32'd1;
    if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_RESET;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= 32'd0;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      bht_q              <= bht_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // A reset arriving while a redirect is pending kills the pulse immediately.
  assign redirect_valid   = redirect_valid_q & ~reset;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference BHT model plus a
// scoreboard queue of expected redirect pulses.
module tb_branch_predictor;

  localparam int IDX_BITS = 4;
  localparam int ENTRIES  = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [1:0]  res_control;
  logic        res_taken;
  logic        res_pred;
  logic [31:0] res_target;
  logic [31:0] res_fallthrough;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_control      (res_control),
    .res_taken        (res_taken),
    .res_pred         (res_pred),
    .res_target       (res_target),
    .res_fallthrough  (res_fallthrough),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct packed {
    logic        valid;
    logic        inReset;
    logic [31:0] pc;
  } redirect_t;

  redirect_t   expQ[$];
  logic [1:0]  modelBht [ENTRIES];
  logic [31:0] modelBranches;
  logic [31:0] modelMisses;
  bit          modelValid = 1'b0;
  int          vectorCount = 0;
  int          missCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'(pc[IDX_BITS+1:2]);
  endfunction

  task automatic applyStimulus(input logic rst, input logic lv, input logic [31:0] lpc,
                               input logic rv, input logic [31:0] rpc,
                               input logic [1:0] ctl, input logic tk, input logic pr,
                               input logic [31:0] tgt, input logic [31:0] fall);
    redirect_t e;
    redirect_t got;
    int        idx;
    reset = rst; lookup_valid = lv; lookup_pc = lpc;
    res_valid = rv; res_pc = rpc; res_control = ctl; res_taken = tk; res_pred = pr;
    res_target = tgt; res_fallthrough = fall;
    #1;
    if (modelValid)
      checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, lv & modelBht[idxOf(lpc)][1]});
    if (rst) checkOutput("redirect_gated_by_reset", {31'd0, redirect_valid}, 32'd0);

    e = '0;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) modelBht[i] = 2'b01;
      modelBranches = 32'd0;
      modelMisses   = 32'd0;
      modelValid    = 1'b1;
      e.inReset     = 1'b1;
    end else if (rv) begin
      e.valid = (tk != pr);
      e.pc    = e.valid ? (tk ? tgt : fall) : 32'd0;
      if (modelBranches != 32'hFFFF_FFFF) modelBranches++;
      if (e.valid && modelMisses != 32'hFFFF_FFFF) modelMisses++;
      if (ctl != 2'd3) begin
        idx = idxOf(rpc);
        if (tk && modelBht[idx] != 2'b11) modelBht[idx] = modelBht[idx] + 2'd1;
        else if (!tk && modelBht[idx] != 2'b00) modelBht[idx] = modelBht[idx] - 2'd1;
      end
    end
    expQ.push_back(e);

    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, got.valid});
    if (got.valid || got.inReset) checkOutput("redirect_pc", redirect_pc, got.pc);
    checkOutput("branch_count", branch_count, modelBranches);
    checkOutput("mispredict_count", mispredict_count, modelMisses);
  endtask

  task automatic lookupOnly(input logic [31:0] pc);
    applyStimulus(1'b0, 1'b1, pc, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [1:0] ctl, input logic tk,
                         input logic pr, input logic [31:0] tgt, input logic [31:0] fall);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, pc, ctl, tk, pr, tgt, fall);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [1:0]  ctl;
    logic        tk;

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    lookupOnly(32'h40);

    resolve(32'h40, 2'd0, 1'b1, 1'b0, 32'h100, 32'h44);
    resolve(32'h40, 2'd0, 1'b1, 1'b0, 32'h100, 32'h44);
    lookupOnly(32'h40);

    for (int i = 0; i < 4; i++) resolve(32'h40, 2'd0, 1'b1, 1'b1, 32'h100, 32'h44);
    resolve(32'h40, 2'd0, 1'b0, 1'b1, 32'h100, 32'h44);
    lookupOnly(32'h40);
    resolve(32'h40, 2'd0, 1'b0, 1'b1, 32'h100, 32'h44);
    lookupOnly(32'h40);

    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 2'd0, 1'b1, 1'b0, 32'h180, 32'h84);
    lookupOnly(32'h80);

    resolve(32'h200, 2'd3, 1'b0, 1'b1, 32'h300, 32'h204);
    lookupOnly(32'h80);

    lookupOnly(32'hC4);
    resolve(32'h44, 2'd1, 1'b1, 1'b0, 32'h500, 32'h48);
    lookupOnly(32'hC4);
    resolve(32'h48, 2'd2, 1'b0, 1'b0, 32'h600, 32'h4C);

    for (int i = 0; i < 40; i++) begin
      rpc = {24'd0, $urandom_range(0, 63) * 4};
      ctl = 2'($urandom_range(0, 3));
      tk  = (ctl == 2'd3) ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), {24'd0, $urandom_range(0, 63) * 4},
                    1'($urandom_range(0, 1)), rpc, ctl, tk, 1'($urandom_range(0, 1)),
                    $urandom, rpc + 32'd4);
    end

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 2'd0, 1'b1, 1'b0, 32'h100, 32'h44);
    lookupOnly(32'h40);
    resolve(32'h40, 2'd0, 1'b1, 1'b0, 32'h100, 32'h44);
    lookupOnly(32'h40);

    resolve(32'h40, 2'd0, 1'b0, 1'b1, 32'h100, 32'h44);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    lookupOnly(32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage of the 5-stage MIPS pipeline, and the counterpart of the branch comparator in decode/execute. Fetch looks up a 2-bit saturating-counter branch history table (BHT) indexed by PC to guess taken/not-taken. When the comparator's resolved outcome returns, the block updates the table, detects a misprediction, and issues a one-cycle redirect to the PC mux. It also keeps branch and misprediction statistics counters.

## Interface

- `IDX_BITS`, default 4: BHT has 2^IDX_BITS entries.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `lookup_valid` in 1: fetch is presenting a branch PC.
- `lookup_pc` in 32: PC of the fetched branch.
- `pred_taken` out 1: prediction for `lookup_pc`.
- `res_valid` in 1: a branch resolves this cycle.
- `res_pc` in 32: PC of the resolving branch.
- `res_control` in 2: comparator condition code. 0 = nonzero, 1 = greater than zero, 2 = less than zero, 3 = never.
- `res_taken` in 1: comparator result.
- `res_pred` in 1: the `pred_taken` value fetch used for this branch, carried down the pipe.
- `res_target` in 32: branch target.
- `res_fallthrough` in 32: PC+4.
- `redirect_valid` out 1: flush younger instructions and load `redirect_pc`.
- `redirect_pc` out 32: corrected fetch PC.
- `branch_count` out 32: resolved branches.
- `mispredict_count` out 32: mispredictions.

## Operation

- Index is `pc[IDX_BITS+1:2]` for both lookup and update.
- Counter encoding:
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Prediction is the counter MSB.
- `pred_taken` is 0 whenever `lookup_valid` is 0.
- Update happens on `res_valid` with `res_control` in 0..2:
  - `res_taken` = 1: increment, saturating at 11.
  - `res_taken` = 0: decrement, saturating at 00.
- `res_control` = 3 never updates the BHT. It is still counted and still checked for misprediction; `res_taken` is 0 for this code.
- Mispredict is `res_valid & (res_taken != res_pred)`.
  - On mispredict, `redirect_pc` is `res_taken ? res_target : res_fallthrough`.
  - On a correct prediction, no redirect is issued.
- Statistics counters:
  - `branch_count` increments on every `res_valid`.
  - `mispredict_count` increments on every mispredict.
  - Both saturate at 0xFFFFFFFF and never wrap.
- Reset values:
  - All BHT entries 01.
  - `redirect_valid` 0, `redirect_pc` 0.
  - Both counters 0.

## Timing

- Lookup is combinational from the BHT registers, with zero-cycle latency.
- The BHT write takes effect at the rising edge that samples `res_valid`.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.
- `redirect_valid` and `redirect_pc` are registered: they assert the cycle after the mispredicting `res_valid`, for exactly one cycle.
- Back-to-back mispredicting resolves produce back-to-back redirect pulses, each carrying its own PC.
- Statistics counters update at the same edge as the BHT.
- Reset dominates every other input. A reset asserted in the same cycle as `res_valid` discards the update, and the next cycle shows reset values.
- Reset asserted the cycle after a mispredict suppresses the pending redirect pulse.

## Structure

- Package `bp_pkg` holds:
  - counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`
  - condition codes `CMP_NEZ`, `CMP_GTZ`, `CMP_LTZ`, `CMP_NEVER`
  - `CTR_RESET = CTR_WNT`
- One sub-module, `sat_counter2`: a 2-bit saturating up/down next-state function (in: `ctr`, `taken`; out: `next`), instantiated once on the update path.
- The BHT is a register array, not memory, so that reset clears it.

## Test plan

- Reset, then lookup PC 0x40 with `lookup_valid` = 1 -> `pred_taken` = 0, both counters 0, `redirect_valid` = 0.
- Two resolves of PC 0x40 with taken=1, pred=0, control=0, target 0x100, fallthrough 0x44:
  - Each resolve -> next-cycle redirect to 0x100.
  - Afterwards, lookup 0x40 -> `pred_taken` = 1.
  - `mispredict_count` = 2.
- Saturation: four taken resolves of PC 0x40, then one not-taken -> `pred_taken` still 1 (counter 10). A second not-taken -> `pred_taken` = 0.
- Same-cycle lookup and update of PC 0x80, starting from counter 01 with taken=1 -> that cycle `pred_taken` = 0; next cycle `pred_taken` = 1.
- control=3, taken=0, pred=1, fallthrough 0x204 -> redirect to 0x204, BHT entry unchanged, `branch_count` +1.
- Aliasing: PCs 0x40 and 0x80 (`IDX_BITS` = 4) share index 0 -> training 0x40 taken changes the prediction for 0x80.
- Reset asserted with `res_valid` -> no redirect, counters 0, entry 01.
